control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter N, default 8, data/switch immediate width.
REQ-002 Parameter A_SIZE, default 3, ALU function width (matches cpuConfig::aluFunc_t).
REQ-003 Parameter R_SIZE, default 3, GPR address width.
REQ-004 Parameter P_SIZE, default 8, program counter width.
REQ-005 Parameter I_SIZE, default 16, instruction width.
REQ-006 clk  input  1  sole clock, all state rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 instrIn  input  I_SIZE  instruction at pcOut, from combinational-read program ROM.
REQ-009 switchIn  input  1  raw "load" push switch (SW8), asynchronous to clk.
REQ-010 pcOut  output  P_SIZE  program ROM address.
REQ-011 aluFunc  output  cpuConfig::aluFunc_t  ALU operation to datapath.
REQ-012 aluImmediate  output  1  select immediate/switch operand B.
REQ-013 immSwitches  output  1  select switches as immediate.
REQ-014 opD  output  R_SIZE  destination/operand-A register address.
REQ-015 opS  output  N  source register address or immediate.
REQ-016 regWrite  output  1  GPR write enable for this cycle.
REQ-017 halted  output  1  high while in HALTED state.

Function
REQ-018 Instruction fields SHALL be: [15:14] class, [13:11] func/subop, [10:8] rd, [7:0] opS/imm/target.
REQ-019 Class 00 (ALU reg): aluImmediate=0, immSwitches=0, regWrite=1, pc<=pc+1, one cycle.
REQ-020 Class 01 (ALU imm): aluImmediate=1, immSwitches=0, regWrite=1, pc<=pc+1, one cycle.
REQ-021 Class 10 (ALU switch): in RUN, regWrite=0, pc held, next state WAIT_PRESS.
REQ-022 Class 11 subop 000 (JMP): regWrite=0, pc<=instr[P_SIZE-1:0].
REQ-023 Class 11 subop 001 (HALT): regWrite=0, pc held, next state HALTED.
REQ-024 Class 11 other subops: NOP, regWrite=0, pc<=pc+1.
REQ-025 aluFunc=instr[13:11], opD=instr[10:8], opS=instr[7:0] in every state, combinationally.
REQ-026 States: RUN, WAIT_PRESS, WAIT_RELEASE, HALTED.
REQ-027 switchIn SHALL pass through a 2-flop synchronizer; swSync is its output (2-cycle latency).
REQ-028 WAIT_PRESS: aluImmediate=1, immSwitches=1; if swSync=1, regWrite=1 for exactly that cycle and go WAIT_RELEASE; else regWrite=0, stay.
REQ-029 WAIT_RELEASE: regWrite=0, immSwitches=1; when swSync=0, pc<=pc+1, go RUN.
REQ-030 HALTED: regWrite=0, pc held, halted=1; exit only by reset.
REQ-031 pc+1 SHALL wrap from 2^P_SIZE-1 to 0; JMP to the current pc SHALL loop indefinitely.
REQ-032 Switch held high before a class-10 instruction is reached SHALL still produce exactly one write, then wait for release.
REQ-033 Exactly one register write per class-10 instruction, regardless of press duration.

Reset
REQ-034 While reset=1: pcOut=0, state=RUN, synchronizer flops=0, halted=0, regWrite forced 0.
REQ-035 Reset asserted in any state, including mid-WAIT_PRESS/WAIT_RELEASE, SHALL return immediately to REQ-034 values; first instruction executes on the first edge after deassertion.

Structure
REQ-036 cpuConfig package SHALL hold aluFunc_t, instrClass_t (ALU_REG, ALU_IMM, ALU_SW, CTRL), and ctrlOp_t (JMP, HALT) encodings; the state enum is local to control_unit.
REQ-037 The synchronizer SHALL be sub-module switch_sync (2 flops, async active-high reset to 0).

Verification
REQ-038 ROM: 0:ADDI r1,5 (0x4105), 1:ADD r2,r1 (0x0201) -> regWrite=1 at pc 0 and 1, pcOut 0->1->2, opS=0x05 then 0x01.
REQ-039 pc 2: class-10 r3, switchIn raised 10 cycles later -> regWrite stays 0 until 2 cycles after the rise, pulses high 1 cycle with immSwitches=1, pc stays 2 until 2 cycles after release, then 3.
REQ-040 switchIn held high continuously across two consecutive class-10 instructions -> one write for the first, no advance until a release; second writes only after a fresh press.
REQ-041 JMP 0x00 at pc 0xFF, and NOP at pc 0xFF -> pcOut=0x00 next cycle in both cases.
REQ-042 HALT at pc 4 -> halted=1, pcOut=4 and regWrite=0 for 20 cycles; reset -> pcOut=0, halted=0.
REQ-043 Reset asserted during WAIT_PRESS -> pcOut=0, regWrite=0 asynchronously, execution resumes at pc 0.

Source files
------------

// File: rtl/cpuConfig.sv
// Shared CPU encodings: ALU functions, instruction classes and control sub-operations.
package cpuConfig;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } aluFunc_t;

    typedef enum logic [1:0] {
        ALU_REG = 2'b00,
        ALU_IMM = 2'b01,
        ALU_SW  = 2'b10,
        CTRL    = 2'b11
    } instrClass_t;

    typedef enum logic [2:0] {
        JMP  = 3'b000,
        HALT = 3'b001
    } ctrlOp_t;

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit (master) and the program ROM / datapath (slave).
interface control_unit_if
    import cpuConfig::*;
#(
    parameter int N      = 8,
    parameter int R_SIZE = 3,
    parameter int P_SIZE = 8,
    parameter int I_SIZE = 16
) ();

    logic [I_SIZE-1:0] instrIn;
    logic              switchIn;
    logic [P_SIZE-1:0] pcOut;
    aluFunc_t          aluFunc;
    logic              aluImmediate;
    logic              immSwitches;
    logic [R_SIZE-1:0] opD;
    logic [N-1:0]      opS;
    logic              regWrite;
    logic              halted;

    modport master (
        input  instrIn, switchIn,
        output pcOut, aluFunc, aluImmediate, immSwitches, opD, opS, regWrite, halted
    );

    modport slave (
        output instrIn, switchIn,
        input  pcOut, aluFunc, aluImmediate, immSwitches, opD, opS, regWrite, halted
    );

endinterface

// File: rtl/switch_sync.sv
// Two-flop synchronizer bringing the raw load switch into the clk domain.
module switch_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: decodes the ROM word, steps the pc and waits on the load
// switch for class-10 instructions so each press produces exactly one register write.
module control_unit
    import cpuConfig::*;
#(
    parameter int N      = 8,
    parameter int A_SIZE = 3,
    parameter int R_SIZE = 3,
    parameter int P_SIZE = 8,
    parameter int I_SIZE = 16
) (
    input  logic clk,
    input  logic reset,
    control_unit_if.master bus
);

    typedef enum logic [1:0] {RUN, WAIT_PRESS, WAIT_RELEASE, HALTED} state_t;

    localparam logic [P_SIZE-1:0] PC_ONE = P_SIZE'(1);

    state_t            state_reg;
    logic [P_SIZE-1:0] pc_reg;
    logic              sw_sync;
    logic [I_SIZE-1:0] instr;
    instrClass_t       instr_class;
    logic [2:0]        subop;
    logic              reg_write_next;
    logic              alu_imm_next;
    logic              imm_sw_next;

    assign instr       = bus.instrIn;
    assign instr_class = instrClass_t'(instr[I_SIZE-1 -: 2]);
    assign subop       = instr[11 +: 3];

    switch_sync u_switch_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.switchIn),
        .q     (sw_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            pc_reg    <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    case (instr_class)
                        ALU_REG, ALU_IMM: pc_reg <= pc_reg + PC_ONE;
                        ALU_SW:           state_reg <= WAIT_PRESS;
                        default: begin
                            if (subop == JMP) begin
                                pc_reg <= instr[P_SIZE-1:0];
                            end else if (subop == HALT) begin
                                state_reg <= HALTED;
                            end else begin
                                pc_reg <= pc_reg + PC_ONE;
                            end
                        end
                    endcase
                end
                // The write happens on the press edge; the release wait keeps a long press from re-writing.
                WAIT_PRESS: begin
                    if (sw_sync) begin
                        state_reg <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!sw_sync) begin
                        pc_reg    <= pc_reg + PC_ONE;
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= HALTED;
            endcase
        end
    end

    always_comb begin
        reg_write_next = 1'b0;
        alu_imm_next   = 1'b0;
        imm_sw_next    = 1'b0;
        case (state_reg)
            RUN: begin
                case (instr_class)
                    ALU_REG: reg_write_next = 1'b1;
                    ALU_IMM: begin
                        reg_write_next = 1'b1;
                        alu_imm_next   = 1'b1;
                    end
                    ALU_SW: begin
                        alu_imm_next = 1'b1;
                        imm_sw_next  = 1'b1;
                    end
                    default: ;
                endcase
            end
            WAIT_PRESS: begin
                alu_imm_next   = 1'b1;
                imm_sw_next    = 1'b1;
                reg_write_next = sw_sync;
            end
            WAIT_RELEASE: begin
                alu_imm_next = 1'b1;
                imm_sw_next  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates the write enable directly so the datapath sees no write while reset is held.
    assign bus.regWrite     = reg_write_next & ~reset;
    assign bus.aluImmediate = alu_imm_next;
    assign bus.immSwitches  = imm_sw_next;
    assign bus.aluFunc      = aluFunc_t'(instr[11 +: A_SIZE]);
    assign bus.opD          = instr[8 +: R_SIZE];
    assign bus.opS          = instr[0 +: N];
    assign bus.pcOut        = pc_reg;
    assign bus.halted       = (state_reg == HALTED);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: vector table for single-cycle instructions plus
// hand sequences for switch handshakes, HALT and asynchronous reset.
module tb_control_unit;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
        logic        rw;
        logic        ai;
        logic        is;
        logic [7:0]  ops;
        logic [2:0]  opd;
        logic [2:0]  func;
        logic [7:0]  nxt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] rom [256];
    int errors = 0;
    int checks = 0;
    int wcount = 0;
    int bad = 0;
    vec_t vecs [11];

    control_unit_if #(.N(8), .R_SIZE(3), .P_SIZE(8), .I_SIZE(16)) bus ();

    control_unit #(.N(8), .A_SIZE(3), .R_SIZE(3), .P_SIZE(8), .I_SIZE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.instrIn = rom[bus.pcOut];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.regWrite === 1'b1) wcount++;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'hD000;
    endtask

    task automatic start_after_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bus.switchIn = 1'b0;
        rom_clear();
        rom[0] = 16'h4105;

        vecs[0]  = '{16'h4105, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 3'd1, 3'd0, 8'h01};
        vecs[1]  = '{16'h0201, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 3'd2, 3'd0, 8'h02};
        vecs[2]  = '{16'h1A33, 8'h02, 1'b1, 1'b0, 1'b0, 8'h33, 3'd2, 3'd3, 8'h03};
        vecs[3]  = '{16'h7C7F, 8'h03, 1'b1, 1'b1, 1'b0, 8'h7F, 3'd4, 3'd7, 8'h04};
        vecs[4]  = '{16'hD000, 8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd2, 8'h05};
        vecs[5]  = '{16'hC0F8, 8'h05, 1'b0, 1'b0, 1'b0, 8'hF8, 3'd0, 3'd0, 8'hF8};
        vecs[6]  = '{16'hC0F8, 8'hF8, 1'b0, 1'b0, 1'b0, 8'hF8, 3'd0, 3'd0, 8'hF8};
        vecs[7]  = '{16'hC0FF, 8'hF8, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd0, 3'd0, 8'hFF};
        vecs[8]  = '{16'hC000, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 8'h00};
        vecs[9]  = '{16'hC0FF, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd0, 3'd0, 8'hFF};
        vecs[10] = '{16'hD800, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd3, 8'h00};

        // Reset state, with an ADDI at pc 0 so an ungated write would show.
        #2;
        check("rst_pc", 32'(bus.pcOut), 32'h0);
        check("rst_rw", 32'(bus.regWrite), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_release_rw", 32'(bus.regWrite), 32'h1);

        for (int v = 0; v < 11; v++) begin
            rom[vecs[v].pc] = vecs[v].instr;
            #1;
            $display("vec %0d pc=0x%02h instr=0x%04h", v, bus.pcOut, bus.instrIn);
            check("vec_pc", 32'(bus.pcOut), 32'(vecs[v].pc));
            check("vec_rw", 32'(bus.regWrite), 32'(vecs[v].rw));
            check("vec_ai", 32'(bus.aluImmediate), 32'(vecs[v].ai));
            check("vec_is", 32'(bus.immSwitches), 32'(vecs[v].is));
            check("vec_ops", 32'(bus.opS), 32'(vecs[v].ops));
            check("vec_opd", 32'(bus.opD), 32'(vecs[v].opd));
            check("vec_func", 32'(bus.aluFunc), 32'(vecs[v].func));
            check("vec_halted", 32'(bus.halted), 32'h0);
            tick();
            check("vec_next_pc", 32'(bus.pcOut), 32'(vecs[v].nxt));
        end

        // Class-10 at pc 2, switch pressed after 10 idle cycles.
        rom_clear();
        rom[0] = 16'h4105;
        rom[1] = 16'h0201;
        rom[2] = 16'h8300;
        rom[3] = 16'h8400;
        rom[4] = 16'h8500;
        rom[5] = 16'hC800;
        start_after_reset();
        tick();
        tick();
        $display("seq press: pc=0x%02h", bus.pcOut);
        check("sw_pc", 32'(bus.pcOut), 32'h2);
        check("sw_run_rw", 32'(bus.regWrite), 32'h0);
        check("sw_run_is", 32'(bus.immSwitches), 32'h1);
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.regWrite !== 1'b0 || bus.pcOut !== 8'h02) bad++;
        end
        check("sw_idle_bad", 32'(bad), 32'h0);
        bus.switchIn = 1'b1;
        check("sw_rise0_rw", 32'(bus.regWrite), 32'h0);
        tick();
        check("sw_rise1_rw", 32'(bus.regWrite), 32'h0);
        tick();
        check("sw_rise2_rw", 32'(bus.regWrite), 32'h1);
        check("sw_rise2_is", 32'(bus.immSwitches), 32'h1);
        check("sw_rise2_ai", 32'(bus.aluImmediate), 32'h1);
        check("sw_rise2_opd", 32'(bus.opD), 32'h3);
        tick();
        check("sw_rise3_rw", 32'(bus.regWrite), 32'h0);
        check("sw_rise3_is", 32'(bus.immSwitches), 32'h1);
        repeat (3) tick();
        check("sw_hold_rw", 32'(bus.regWrite), 32'h0);
        check("sw_hold_pc", 32'(bus.pcOut), 32'h2);
        bus.switchIn = 1'b0;
        tick();
        tick();
        check("sw_rel2_pc", 32'(bus.pcOut), 32'h2);
        tick();
        check("sw_rel3_pc", 32'(bus.pcOut), 32'h3);

        // Switch already high when the next two class-10 instructions arrive.
        $display("seq held: pc=0x%02h", bus.pcOut);
        bus.switchIn = 1'b1;
        wcount = 0;
        repeat (10) tick();
        check("held_writes", 32'(wcount), 32'h1);
        check("held_pc", 32'(bus.pcOut), 32'h3);
        bus.switchIn = 1'b0;
        wcount = 0;
        repeat (6) tick();
        check("held_rel_pc", 32'(bus.pcOut), 32'h4);
        check("held_rel_writes", 32'(wcount), 32'h0);
        bus.switchIn = 1'b1;
        repeat (6) tick();
        check("second_writes", 32'(wcount), 32'h1);
        check("second_pc", 32'(bus.pcOut), 32'h4);
        bus.switchIn = 1'b0;
        repeat (6) tick();
        check("second_rel_pc", 32'(bus.pcOut), 32'h5);
        check("second_halted", 32'(bus.halted), 32'h1);
        check("second_total_writes", 32'(wcount), 32'h1);

        // HALT at pc 4, then asynchronous reset out of HALTED.
        rom_clear();
        rom[4] = 16'hC800;
        start_after_reset();
        repeat (4) tick();
        $display("seq halt: pc=0x%02h", bus.pcOut);
        check("halt_run_rw", 32'(bus.regWrite), 32'h0);
        check("halt_run_halted", 32'(bus.halted), 32'h0);
        tick();
        bad = 0;
        repeat (20) begin
            if (bus.halted !== 1'b1 || bus.pcOut !== 8'h04 || bus.regWrite !== 1'b0) bad++;
            tick();
        end
        check("halt_bad_cycles", 32'(bad), 32'h0);
        rom[0] = 16'h4105;
        reset = 1'b1;
        #2;
        check("halt_rst_pc", 32'(bus.pcOut), 32'h0);
        check("halt_rst_halted", 32'(bus.halted), 32'h0);
        check("halt_rst_rw", 32'(bus.regWrite), 32'h0);
        reset = 1'b0;
        #1;
        check("halt_resume_rw", 32'(bus.regWrite), 32'h1);
        tick();
        check("halt_resume_pc", 32'(bus.pcOut), 32'h1);

        // Asynchronous reset in the middle of a WAIT_PRESS write cycle.
        rom_clear();
        rom[0] = 16'h4105;
        rom[1] = 16'h8100;
        start_after_reset();
        tick();
        tick();
        $display("seq wp_reset: pc=0x%02h", bus.pcOut);
        check("wp_pc", 32'(bus.pcOut), 32'h1);
        check("wp_is", 32'(bus.immSwitches), 32'h1);
        check("wp_rw", 32'(bus.regWrite), 32'h0);
        bus.switchIn = 1'b1;
        tick();
        tick();
        check("wp_press_rw", 32'(bus.regWrite), 32'h1);
        reset = 1'b1;
        #2;
        check("wp_rst_rw", 32'(bus.regWrite), 32'h0);
        check("wp_rst_pc", 32'(bus.pcOut), 32'h0);
        check("wp_rst_is", 32'(bus.immSwitches), 32'h0);
        bus.switchIn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("wp_resume_rw", 32'(bus.regWrite), 32'h1);
        check("wp_resume_pc0", 32'(bus.pcOut), 32'h0);
        tick();
        check("wp_resume_pc1", 32'(bus.pcOut), 32'h1);
        check("wp_resume_rw1", 32'(bus.regWrite), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
